// File: rtl/branch_hazard_ctrl_if.sv
// Decode-side bundle of the branch hazard controller: the decode
// instruction fields and freeze going in, the stall/bubble/forward
// controls and the stall counter coming out.

`ifndef OPCODE_SIZE
`define OPCODE_SIZE 7
`endif
`ifndef REGFILE_LOGSIZE
`define REGFILE_LOGSIZE 5
`endif
`ifndef LOAD_OP
`define LOAD_OP 7'b0000011
`endif
`ifndef BTYPE_OP
`define BTYPE_OP 7'b1100011
`endif
`ifndef JALR_OP
`define JALR_OP 7'b1100111
`endif

interface branch_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic                          id_valid;
  logic [`OPCODE_SIZE-1:0]       id_opcode;
  logic [`REGFILE_LOGSIZE-1:0]   id_rs1;
  logic [`REGFILE_LOGSIZE-1:0]   id_rs2;
  logic [`REGFILE_LOGSIZE-1:0]   id_rd;
  logic                          id_wr_en;
  logic                          id_flush;
  logic                          ext_stall;
  logic                          stall_fd;
  logic                          bubble_e;
  logic [1:0]                    br_fwsel1;
  logic [1:0]                    br_fwsel2;
  logic [CNT_W-1:0]              stall_cnt;

  // Pipeline/decode side: drives the instruction, observes the controls
  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, id_wr_en,
           id_flush, ext_stall,
    input  stall_fd, bubble_e, br_fwsel1, br_fwsel2, stall_cnt
  );

  // Hazard controller side
  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, id_wr_en,
           id_flush, ext_stall,
    output stall_fd, bubble_e, br_fwsel1, br_fwsel2, stall_cnt
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// Decode-stage hazard controller for branches and jalr. Shadows the
// destination registers of the EX, MEM and WB instructions and decides
// whether the branch operands come from the register file, a forward
// path, or require a stall. Also counts branch-hazard stall cycles.

`ifndef OPCODE_SIZE
`define OPCODE_SIZE 7
`endif
`ifndef REGFILE_LOGSIZE
`define REGFILE_LOGSIZE 5
`endif
`ifndef LOAD_OP
`define LOAD_OP 7'b0000011
`endif
`ifndef BTYPE_OP
`define BTYPE_OP 7'b1100011
`endif
`ifndef JALR_OP
`define JALR_OP 7'b1100111
`endif

module branch_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input logic                  clk,
  input logic                  rst,
  branch_hazard_ctrl_if.slave  bus
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  typedef struct packed {
    logic                        wr_en;
    logic [`REGFILE_LOGSIZE-1:0] rd;
    logic                        is_load;
  } slot_t;

  slot_t            slot_e, slot_m, slot_w;
  logic [CNT_W-1:0] cnt;

  logic       is_branch;
  logic       stall1, stall2;
  logic [1:0] sel1, sel2;
  logic       hz;

  // A slot supplies rs when it writes that register; x0 is never a producer
  function automatic logic slot_match(slot_t s, logic [`REGFILE_LOGSIZE-1:0] rs);
    return s.wr_en && (s.rd == rs) && (rs != '0);
  endfunction

  // Per-operand resolution: youngest producer wins, EX always stalls,
  // a load in MEM stalls, an ALU result in MEM or anything in WB forwards
  function automatic logic [2:0] resolve(logic [`REGFILE_LOGSIZE-1:0] rs,
                                         slot_t e, slot_t m, slot_t w);
    logic [2:0] r;
    r = {1'b0, SEL_RF};
    if (slot_match(e, rs))
      r = {1'b1, SEL_RF};
    else if (slot_match(m, rs))
      r = m.is_load ? {1'b1, SEL_RF} : {1'b0, SEL_MEM};
    else if (slot_match(w, rs))
      r = {1'b0, SEL_WB};
    return r;
  endfunction

  // Zero-latency hazard decision from decode inputs and tracker state
  always_comb begin
    is_branch = bus.id_valid && !bus.id_flush &&
                ((bus.id_opcode == `BTYPE_OP) || (bus.id_opcode == `JALR_OP));
    {stall1, sel1} = resolve(bus.id_rs1, slot_e, slot_m, slot_w);
    {stall2, sel2} = resolve(bus.id_rs2, slot_e, slot_m, slot_w);
    hz = is_branch && (stall1 || stall2);
    bus.stall_fd  = hz;
    bus.bubble_e  = hz || bus.id_flush;
    bus.br_fwsel1 = (is_branch && !hz) ? sel1 : SEL_RF;
    bus.br_fwsel2 = (is_branch && !hz) ? sel2 : SEL_RF;
    bus.stall_cnt = cnt;
  end

  // Tracker shift: frozen by ext_stall, EX takes a bubble when decode does not issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_e <= '0;
      slot_m <= '0;
      slot_w <= '0;
    end else if (!bus.ext_stall) begin
      slot_w <= slot_m;
      slot_m <= slot_e;
      if (bus.bubble_e || !bus.id_valid)
        slot_e <= '0;
      else
        slot_e <= '{wr_en:   bus.id_wr_en,
                    rd:      bus.id_rd,
                    is_load: (bus.id_opcode == `LOAD_OP)};
    end
  end

  // Saturating count of cycles this block actually held the front end
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (hz && !bus.ext_stall && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: instruction sequences with
// hand-computed stall, bubble, forward-select and counter values.

`ifndef OPCODE_SIZE
`define OPCODE_SIZE 7
`endif
`ifndef REGFILE_LOGSIZE
`define REGFILE_LOGSIZE 5
`endif

module tb_branch_hazard_ctrl;

  localparam logic [6:0] OP_ALUI = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  branch_hazard_ctrl_if #(.CNT_W(32)) bus ();

  branch_hazard_ctrl #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-derived expectation
  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the whole output set in one go
  task automatic check_all(input string tag, input logic sfd, input logic bub,
                           input logic [1:0] f1, input logic [1:0] f2,
                           input logic [31:0] cnt);
    check_output({tag, ".stall_fd"},  32'(bus.stall_fd),  32'(sfd));
    check_output({tag, ".bubble_e"},  32'(bus.bubble_e),  32'(bub));
    check_output({tag, ".fwsel1"},    32'(bus.br_fwsel1), 32'(f1));
    check_output({tag, ".fwsel2"},    32'(bus.br_fwsel2), 32'(f2));
    check_output({tag, ".stall_cnt"}, bus.stall_cnt,      cnt);
  endtask

  // Present a decode instruction and let the combinational outputs settle
  task automatic apply_stimulus(input logic [6:0] op, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic wr_en);
    bus.id_valid  = 1'b1;
    bus.id_opcode = op;
    bus.id_rs1    = rs1;
    bus.id_rs2    = rs2;
    bus.id_rd     = rd;
    bus.id_wr_en  = wr_en;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_nop();
    apply_stimulus(OP_ALUI, 5'd0, 5'd0, 5'd0, 1'b1);
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.id_valid  = 1'b0;
    bus.id_opcode = '0;
    bus.id_rs1    = '0;
    bus.id_rs2    = '0;
    bus.id_rd     = '0;
    bus.id_wr_en  = 1'b0;
    bus.id_flush  = 1'b0;
    bus.ext_stall = 1'b0;
    #1;
    check_all("reset", 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    step();

    // addi x1 ; beq x1,x5 : one stall, then MEM forward
    apply_stimulus(OP_ALUI, 5'd0, 5'd0, 5'd1, 1'b1);
    check_all("alu_issue", 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
    step();
    apply_stimulus(OP_BR, 5'd1, 5'd5, 5'd0, 1'b0);
    check_all("alu_br_stall", 1'b1, 1'b1, 2'b00, 2'b00, 32'd0);
    step();
    check_all("alu_br_fwd", 1'b0, 1'b0, 2'b01, 2'b00, 32'd1);
    step();

    // lw x3 ; bne x3,x0 : two stalls, then WB forward
    apply_stimulus(OP_LOAD, 5'd2, 5'd0, 5'd3, 1'b1);
    step();
    apply_stimulus(OP_BR, 5'd3, 5'd0, 5'd0, 1'b0);
    check_all("ld_br_stall1", 1'b1, 1'b1, 2'b00, 2'b00, 32'd1);
    step();
    check_all("ld_br_stall2", 1'b1, 1'b1, 2'b00, 2'b00, 32'd2);
    step();
    check_all("ld_br_fwd", 1'b0, 1'b0, 2'b10, 2'b00, 32'd3);
    step();

    // Load one ahead with an independent instruction between: one stall, then WB
    apply_stimulus(OP_LOAD, 5'd2, 5'd0, 5'd9, 1'b1);
    step();
    issue_nop();
    apply_stimulus(OP_BR, 5'd9, 5'd0, 5'd0, 1'b0);
    check_all("ld_gap_stall", 1'b1, 1'b1, 2'b00, 2'b00, 32'd3);
    step();
    check_all("ld_gap_fwd", 1'b0, 1'b0, 2'b10, 2'b00, 32'd4);
    step();

    // addi x1 ; N nops ; beq x2,x1
    for (int n = 1; n <= 3; n++) begin
      apply_stimulus(OP_ALUI, 5'd0, 5'd0, 5'd1, 1'b1);
      step();
      for (int k = 0; k < n; k++) issue_nop();
      apply_stimulus(OP_BR, 5'd2, 5'd1, 5'd0, 1'b0);
      case (n)
        1: check_all("dist1", 1'b0, 1'b0, 2'b00, 2'b01, 32'd4);
        2: check_all("dist2", 1'b0, 1'b0, 2'b00, 2'b10, 32'd4);
        default: check_all("dist3", 1'b0, 1'b0, 2'b00, 2'b00, 32'd4);
      endcase
      step();
    end

    // addi x4 ; addi x4 ; nop ; jalr x4 : the MEM producer wins over WB
    apply_stimulus(OP_ALUI, 5'd0, 5'd0, 5'd4, 1'b1);
    step();
    apply_stimulus(OP_ALUI, 5'd4, 5'd0, 5'd4, 1'b1);
    step();
    issue_nop();
    apply_stimulus(OP_JALR, 5'd4, 5'd0, 5'd1, 1'b1);
    check_all("youngest", 1'b0, 1'b0, 2'b01, 2'b00, 32'd4);
    step();

    // addi x0 ; beq x0,x0 : x0 never matches
    apply_stimulus(OP_ALUI, 5'd0, 5'd0, 5'd0, 1'b1);
    step();
    apply_stimulus(OP_BR, 5'd0, 5'd0, 5'd0, 1'b0);
    check_all("x0_nomatch", 1'b0, 1'b0, 2'b00, 2'b00, 32'd4);
    step();

    // Hazarding beq with flush: flush wins, no count
    apply_stimulus(OP_ALUI, 5'd0, 5'd0, 5'd6, 1'b1);
    step();
    bus.id_flush = 1'b1;
    apply_stimulus(OP_BR, 5'd6, 5'd6, 5'd0, 1'b0);
    check_all("flush", 1'b0, 1'b1, 2'b00, 2'b00, 32'd4);
    step();
    bus.id_flush = 1'b0;
    issue_nop();
    check_output("flush_nocount", bus.stall_cnt, 32'd4);

    // Hazard under ext_stall for 3 cycles: held, no shift, no count
    apply_stimulus(OP_ALUI, 5'd0, 5'd0, 5'd7, 1'b1);
    step();
    bus.ext_stall = 1'b1;
    apply_stimulus(OP_BR, 5'd7, 5'd0, 5'd0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      check_all("freeze", 1'b1, 1'b1, 2'b00, 2'b00, 32'd4);
      step();
    end
    bus.ext_stall = 1'b0;
    #1;
    check_all("freeze_release", 1'b1, 1'b1, 2'b00, 2'b00, 32'd4);
    step();
    check_all("freeze_fwd", 1'b0, 1'b0, 2'b01, 2'b00, 32'd5);
    step();

    // Reset pulsed mid-stall clears outputs immediately
    apply_stimulus(OP_ALUI, 5'd0, 5'd0, 5'd8, 1'b1);
    step();
    apply_stimulus(OP_BR, 5'd8, 5'd0, 5'd0, 1'b0);
    check_all("pre_reset", 1'b1, 1'b1, 2'b00, 2'b00, 32'd5);
    #2 rst = 1'b1;
    #1;
    check_all("mid_reset", 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check_all("post_reset", 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
